// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port unified memory between the instruction-fetch
// requester (IF stage) and the data requester (MEM stage). Data accesses win
// by default because they belong to the older instruction. A streak counter
// limits how many data grants can pass a waiting fetch, so fetch always makes
// progress. The block also raises the pipeline stall while either requester
// is still waiting.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   i_req, i_addr         fetch request and address (held until i_done)
//   i_done, i_rdata       fetch completion pulse and registered fetch data
//   d_req, d_we, d_addr,
//   d_wdata               data request, store flag, address and store data
//   d_done, d_rdata       data completion pulse and registered load data
//   mem_req, mem_we,
//   mem_addr, mem_wdata   memory request side (registered address/data)
//   mem_ack, mem_rdata    memory completion pulse and read data
//   stall                 pipeline stall while any requester is waiting
//   err                   sticky flag for an acknowledge nobody asked for
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                ownerData_q, ownerData_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [DATA_W-1:0]   memWdata_q, memWdata_d;
  logic [DATA_W-1:0]   iRdata_q, iRdata_d;
  logic [DATA_W-1:0]   dRdata_q, dRdata_d;
  logic                err_q, err_d;
  logic                streakAtMax;
  logic                busy;

  assign streakAtMax = (streak_q == STREAK_MAX);
  assign busy        = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Next-state logic: arbitration in IDLE latches the winner's command,
  // BUSY waits for the memory acknowledge and captures read data, RESP
  // spends exactly one cycle presenting the done pulse.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    ownerData_d = ownerData_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    iRdata_d    = iRdata_q;
    dRdata_d    = dRdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // A waiting fetch only overrides data once the streak is used up.
        if (d_req && !(i_req && streakAtMax)) begin
          state_d     = BUSY_D;
          ownerData_d = 1'b1;
          memWe_d     = d_we;
          memAddr_d   = d_addr;
          memWdata_d  = d_wdata;
          // Reaching this branch with i_req high implies the streak is
          // below its limit, so the increment can never overflow.
          if (i_req) begin
            streak_d = streak_q + STREAK_W'(1);
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d     = BUSY_I;
          ownerData_d = 1'b0;
          memWe_d     = 1'b0;
          memAddr_d   = i_addr;
          memWdata_d  = '0;
          streak_d    = '0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          iRdata_d = mem_rdata;
          state_d  = RESP;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          // Stores leave the load data register untouched.
          if (!memWe_q) begin
            dRdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An acknowledge outside a memory transaction is a protocol error.
    if (mem_ack && !busy) begin
      err_d = 1'b1;
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      ownerData_q <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      iRdata_q    <= '0;
      dRdata_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      ownerData_q <= ownerData_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      iRdata_q    <= iRdata_d;
      dRdata_q    <= dRdata_d;
      err_q       <= err_d;
    end
  end

  // mem_req is decoded from the state so that an asynchronous reset
  // withdraws it immediately.
  assign mem_req   = busy;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign i_done    = (state_q == RESP) && !ownerData_q;
  assign d_done    = (state_q == RESP) && ownerData_q;
  assign i_rdata   = iRdata_q;
  assign d_rdata   = dRdata_q;
  assign err       = err_q;
  assign stall     = (i_req && !i_done) || (d_req && !d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives mem_port_arbiter cycle by cycle from a single initial block. The
// bench plays both requesters and the memory, and keeps a transaction-level
// model of the arbiter: when it is free, who wins, when the acknowledge
// arrives and what data each requester should end up holding.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int MAX_STREAK = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_done(i_done),
    .i_rdata(i_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_done(d_done),
    .d_rdata(d_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .stall(stall),
    .err(err)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // Requester and memory behaviour
  bit          iPend, dPend, dWeV;
  logic [63:0] iAddrV, dAddrV, dWdataV;
  bit          autoGen, dRepeat, spuriousNow, randDelay;
  int          dRepeatCount, ackDelay;
  logic [63:0] memArr [logic [63:0]];

  // Arbiter model
  bit          haveTxn, txnData, txnWe;
  int          gCyc, aCyc, streak;
  logic [63:0] txnAddr, txnWdata, expI, expD;
  bit          expErr;

  // Observations of the DUT used by ordering checks
  bit          prevMemReq, obsEnable, obsFetchSeen;
  int          obsDataGrants, lastIDoneCyc, lastDDoneCyc;
  logic [63:0] starveFetchAddr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] memRead(input logic [63:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
  endfunction

  // One clock cycle: entered just after a rising edge, drives requesters and
  // memory, advances the model, checks outputs on the falling edge.
  task automatic applyStimulus();
    bit reqExp, ackNow, iDoneExp, dDoneExp, nextErr;
    logic [63:0] nextI, nextD;

    if (haveTxn && cyc >= aCyc + 2) begin
      haveTxn = 1'b0;
      if (txnData) dPend = 1'b0;
      else         iPend = 1'b0;
    end

    if (autoGen) begin
      if (!iPend && $urandom_range(0, 2) == 0) begin
        iPend  = 1'b1;
        iAddrV = 64'h1000 + 64'($urandom_range(0, 31)) * 64'd8;
      end
      if (!dPend && $urandom_range(0, 2) == 0) begin
        dPend   = 1'b1;
        dWeV    = 1'($urandom_range(0, 1));
        dAddrV  = 64'h1000 + 64'($urandom_range(0, 31)) * 64'd8;
        dWdataV = {$urandom, $urandom};
      end
    end
    if (dRepeat && !dPend) begin
      dPend   = 1'b1;
      dWeV    = 1'b0;
      dAddrV  = 64'h300 + 64'(dRepeatCount) * 64'd8;
      dWdataV = 64'h0;
      dRepeatCount++;
    end

    i_req   = iPend;
    i_addr  = iAddrV;
    d_req   = dPend;
    d_we    = dWeV;
    d_addr  = dAddrV;
    d_wdata = dWdataV;

    if (!haveTxn && (iPend || dPend)) begin
      haveTxn = 1'b1;
      gCyc    = cyc;
      aCyc    = cyc + 1 + (randDelay ? int'($urandom_range(0, 3)) : ackDelay);
      if (dPend && !(iPend && streak == MAX_STREAK)) begin
        txnData  = 1'b1;
        txnWe    = dWeV;
        txnAddr  = dAddrV;
        txnWdata = dWdataV;
        if (iPend) streak = (streak < MAX_STREAK) ? streak + 1 : MAX_STREAK;
        else       streak = 0;
      end else begin
        txnData  = 1'b0;
        txnWe    = 1'b0;
        txnAddr  = iAddrV;
        txnWdata = 64'h0;
        streak   = 0;
      end
    end

    reqExp   = haveTxn && cyc > gCyc && cyc <= aCyc;
    ackNow   = haveTxn && cyc == aCyc;
    iDoneExp = haveTxn && cyc == aCyc + 1 && !txnData;
    dDoneExp = haveTxn && cyc == aCyc + 1 && txnData;
    nextI    = expI;
    nextD    = expD;
    nextErr  = expErr;

    mem_rdata = {$urandom, $urandom};
    if (ackNow) begin
      if (txnWe) begin
        memArr[txnAddr] = txnWdata;
      end else begin
        mem_rdata = memRead(txnAddr);
        if (txnData) nextD = mem_rdata;
        else         nextI = mem_rdata;
      end
    end
    mem_ack = ackNow || spuriousNow;
    if (spuriousNow && !reqExp) nextErr = 1'b1;
    spuriousNow = 1'b0;

    @(negedge clk);
    checkOutput("mem_req", mem_req, reqExp);
    if (reqExp) begin
      checkOutput("mem_addr", mem_addr, txnAddr);
      checkOutput("mem_we", mem_we, txnWe);
      if (txnData) checkOutput("mem_wdata", mem_wdata, txnWdata);
    end
    checkOutput("i_done", i_done, iDoneExp);
    checkOutput("d_done", d_done, dDoneExp);
    checkOutput("stall", stall, (iPend && !iDoneExp) || (dPend && !dDoneExp));
    checkOutput("err", err, expErr);
    checkOutput("i_rdata", i_rdata, expI);
    checkOutput("d_rdata", d_rdata, expD);

    if (obsEnable && mem_req && !prevMemReq && !obsFetchSeen) begin
      if (mem_addr == starveFetchAddr) obsFetchSeen = 1'b1;
      else                             obsDataGrants++;
    end
    prevMemReq = mem_req;
    if (i_done) lastIDoneCyc = cyc;
    if (d_done) lastDDoneCyc = cyc;

    expI   = nextI;
    expD   = nextD;
    expErr = nextErr;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs cycles until every request has completed and the arbiter is free.
  task automatic drain();
    int n = 0;
    while ((haveTxn || iPend || dPend) && n < 80) begin
      applyStimulus();
      n++;
    end
    if (n >= 80) begin
      nFails++;
      $display("[TB] FAIL drain_timeout observed=%0d cycles required<80", n);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    iPend = 0; dPend = 0; dWeV = 0; iAddrV = '0; dAddrV = '0; dWdataV = '0;
    autoGen = 0; dRepeat = 0; spuriousNow = 0; randDelay = 0; dRepeatCount = 0; ackDelay = 1;
    haveTxn = 0; txnData = 0; txnWe = 0; gCyc = 0; aCyc = 0; streak = 0;
    txnAddr = '0; txnWdata = '0; expI = '0; expD = '0; expErr = 0;
    prevMemReq = 0; obsEnable = 0; obsFetchSeen = 0; obsDataGrants = 0;
    lastIDoneCyc = -1; lastDDoneCyc = -1; starveFetchAddr = 64'h2000;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_i_done", i_done, 0);
    checkOutput("rst_d_done", d_done, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_stall", stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Fetch only, acknowledge two cycles after the request appears
    memArr[64'h40] = 64'h8B1F_0000_0000_0001;
    iPend = 1; iAddrV = 64'h40; ackDelay = 2;
    drain();
    checkOutput("fetch_rdata", i_rdata, 64'h8B1F_0000_0000_0001);

    // Simultaneous fetch and load: data first, fetch at least 3 cycles later
    lastIDoneCyc = -1; lastDDoneCyc = -1;
    iPend = 1; iAddrV = 64'h80;
    dPend = 1; dWeV = 0; dAddrV = 64'h100; ackDelay = 1;
    drain();
    checkOutput("simul_order", (lastDDoneCyc >= 0) && (lastIDoneCyc - lastDDoneCyc >= 3), 1);

    // Starvation guard: fetch held, data re-requested back to back
    obsEnable = 1; obsFetchSeen = 0; obsDataGrants = 0; dRepeatCount = 0;
    iPend = 1; iAddrV = starveFetchAddr; dRepeat = 1; ackDelay = 1;
    for (int n = 0; n < 120 && iPend; n++) applyStimulus();
    dRepeat = 0;
    drain();
    obsEnable = 0;
    checkOutput("starve_data_grants", obsDataGrants, MAX_STREAK);
    checkOutput("starve_fetch_seen", obsFetchSeen, 1);

    // Store acknowledged in the first request cycle
    dPend = 1; dWeV = 1; dAddrV = 64'h200; dWdataV = 64'hDEAD_BEEF_CAFE_F00D; ackDelay = 0;
    drain();

    // Spurious acknowledge while idle sets a sticky error
    spuriousNow = 1;
    applyStimulus();
    repeat (3) applyStimulus();
    checkOutput("err_sticky", err, 1);

    // Randomized traffic with random memory latency
    autoGen = 1; randDelay = 1;
    repeat (400) applyStimulus();
    autoGen = 0; randDelay = 0;
    drain();

    // Reset in the middle of a load, with a fetch waiting
    dPend = 1; dWeV = 0; dAddrV = 64'h500; ackDelay = 6;
    applyStimulus();
    applyStimulus();
    iPend = 1; iAddrV = 64'h40;
    i_req = 1'b1; i_addr = iAddrV; mem_ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_mem_req", mem_req, 0);
    checkOutput("midrst_d_done", d_done, 0);
    checkOutput("midrst_i_done", i_done, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_d_rdata", d_rdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dPend = 0; haveTxn = 0; streak = 0; expI = '0; expD = '0; expErr = 0; prevMemReq = 0;
    cyc++;
    ackDelay = 1;
    drain();
    checkOutput("post_rst_fetch", i_rdata, 64'h8B1F_0000_0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
